// File: rtl/alu_cmd_issuer_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU command issuer: the fixed ALU function
//   encoding, the function-code width, and a decode helper that reports
//   whether a function code names a defined ALU operation.
//
//   Function encoding:
//     0000 add    0001 sub    0010 eq (1/0)    0011 unsigned less-than (1/0)
//     0101 and    0110 or     0111 xor
//     anything else: the ALU returns 0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_FUNC_W = 4;

  localparam logic [ALU_FUNC_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_FUNC_W-1:0] ALU_EQ  = 4'b0010;
  localparam logic [ALU_FUNC_W-1:0] ALU_LTU = 4'b0011;
  localparam logic [ALU_FUNC_W-1:0] ALU_AND = 4'b0101;
  localparam logic [ALU_FUNC_W-1:0] ALU_OR  = 4'b0110;
  localparam logic [ALU_FUNC_W-1:0] ALU_XOR = 4'b0111;

  // True for the seven defined operations; 0100 and every 1xxx code are
  // undefined and make the ALU return 0.
  function automatic logic is_legal_func(input logic [ALU_FUNC_W-1:0] func);
    logic legal;
    legal = 1'b0;
    case (func)
      ALU_ADD, ALU_SUB, ALU_EQ, ALU_LTU,
      ALU_AND, ALU_OR,  ALU_XOR: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer_if
//   Bundles the three buses around the ALU command issuer:
//     cmd_*  : command producer -> issuer  (valid/ready)
//     alu_*  : issuer <-> external combinational ALU (a, b, func out; y in)
//     rsp_*  : issuer -> result consumer   (valid/ready)
//
//   Handshake rule for both cmd and rsp: a transfer happens at a rising clock
//   edge where valid and ready are both high. The source must hold valid and
//   its payload stable until that edge; ready may change freely and is never
//   allowed to depend combinationally on valid from the same side.
//
//   Modports:
//     master : the issuer (drives cmd_ready, alu_a/b/func, rsp_*)
//     slave  : the environment (producer, ALU, consumer)
// ---------------------------------------------------------------------------
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  // command port
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ALU_FUNC_W-1:0] cmd_func;
  logic [WIDTH-1:0]      cmd_a;
  logic [WIDTH-1:0]      cmd_b;

  // ALU operand port
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [ALU_FUNC_W-1:0] alu_func;
  logic [WIDTH-1:0]      alu_y;

  // response port
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic [ALU_FUNC_W-1:0] rsp_func;
  logic                  rsp_illegal;

  modport master (
    input  cmd_valid, cmd_func, cmd_a, cmd_b,
    output cmd_ready,
    output alu_a, alu_b, alu_func,
    input  alu_y,
    output rsp_valid, rsp_y, rsp_func, rsp_illegal,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_func, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_a, alu_b, alu_func,
    output alu_y,
    input  rsp_valid, rsp_y, rsp_func, rsp_illegal,
    output rsp_ready
  );

endinterface

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
//   Synchronous FIFO holding packed ALU commands.
//
//   Parameters:
//     DW    : entry width in bits
//     DEPTH : number of entries (power of two, >= 2)
//
//   Ports:
//     clk, rst : rising-edge clock, asynchronous active-high reset
//     push     : write wdata (ignored when full)
//     wdata    : entry to write
//     pop      : discard the head entry (ignored when empty)
//     rdata    : current head entry (meaningful only when !empty)
//     full     : DEPTH entries held
//     empty    : no entries held
//
//   Pointers carry one extra bit beyond the index: equal pointers mean
//   empty, pointers differing only in that top bit mean full. They wrap
//   naturally on overflow.
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DW    = 68,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [DW-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//   Initiator side of an ALU operand interface. Commands {func, a, b} from a
//   valid/ready producer are buffered in a small FIFO, driven one per cycle
//   onto an external combinational ALU, and each ALU result is registered
//   and returned in command order on a valid/ready response port.
//
//   Parameters:
//     WIDTH : operand/result width (must match the interface and the ALU)
//     DEPTH : command FIFO entries (power of two, >= 2)
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : alu_cmd_issuer_if.master
//              cmd_valid/cmd_ready/cmd_func/cmd_a/cmd_b   command in
//              alu_a/alu_b/alu_func -> ALU, alu_y <- ALU  operand bus
//              rsp_valid/rsp_ready/rsp_y/rsp_func/
//              rsp_illegal                                response out
//
//   Optional feature (macro ALU_CMD_ISSUER_ILLEGAL_CHK_EN):
//     defined   : rsp_illegal is registered alongside each result and is 1
//                 when the func code is not a defined ALU operation.
//     undefined : rsp_illegal is tied to 0 and no decode logic exists.
//
//   Timing: a command accepted at edge E is issued at E+1 when the response
//   register is free (or being drained), giving one result per cycle while
//   rsp_ready stays high. With rsp_ready low the block absorbs DEPTH+1
//   commands: DEPTH in the FIFO plus one in the response register.
// ---------------------------------------------------------------------------
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_issuer_if.master bus
);

  localparam int DW = 2 * WIDTH + ALU_FUNC_W;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [DW-1:0]         fifo_wdata;
  logic [DW-1:0]         fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  issue;

  logic [ALU_FUNC_W-1:0] head_func;
  logic [WIDTH-1:0]      head_a;
  logic [WIDTH-1:0]      head_b;

  assign fifo_wdata = {bus.cmd_func, bus.cmd_a, bus.cmd_b};

  // cmd_ready looks only at full, so a pop in the same cycle does not open
  // a slot early; there is no bypass path from cmd_* to the ALU.
  assign bus.cmd_ready = !fifo_full;
  assign push          = bus.cmd_valid && !fifo_full;

  cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (issue),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_func = fifo_head[DW-1 -: ALU_FUNC_W];
  assign head_a    = fifo_head[2*WIDTH-1 -: WIDTH];
  assign head_b    = fifo_head[WIDTH-1:0];

  // ---------------------------------------------------------------------
  // ALU drive: head of the FIFO, or an add of 0+0 while nothing is queued
  // so the ALU inputs never show stale storage contents.
  // ---------------------------------------------------------------------
  assign bus.alu_a    = fifo_empty ? '0 : head_a;
  assign bus.alu_b    = fifo_empty ? '0 : head_b;
  assign bus.alu_func = fifo_empty ? ALU_ADD : head_func;

  // ---------------------------------------------------------------------
  // Issue / response register
  // ---------------------------------------------------------------------
  logic                  rsp_valid_q;
  logic [WIDTH-1:0]      rsp_y_q;
  logic [ALU_FUNC_W-1:0] rsp_func_q;

  // The response register can take a new result when it is empty or its
  // current result leaves at this same edge.
  assign issue = !fifo_empty && (!rsp_valid_q || bus.rsp_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_func_q  <= '0;
    end else if (issue) begin
      rsp_valid_q <= 1'b1;
      rsp_y_q     <= bus.alu_y;
      rsp_func_q  <= head_func;
    end else if (bus.rsp_ready) begin
      // drained with nothing behind it; rsp_y keeps its last value
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_func  = rsp_func_q;

`ifdef ALU_CMD_ISSUER_ILLEGAL_CHK_EN
  logic rsp_illegal_q;

  // Undefined codes still go to the ALU (which returns 0); the flag only
  // tells the consumer that the zero is not an arithmetic result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_illegal_q <= 1'b0;
    end else if (issue) begin
      rsp_illegal_q <= !is_legal_func(head_func);
    end
  end

  assign bus.rsp_illegal = rsp_illegal_q;
`else
  assign bus.rsp_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
//   Bench for alu_cmd_issuer: a behavioural ALU hangs on the operand bus, a
//   monitor predicts every response from accepted commands and compares the
//   response stream in order, and directed sequences cover reset, latency,
//   back-to-back issue, capacity, illegal codes and a mid-cycle reset,
//   followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int EW    = WIDTH + 4 + 1;   // {illegal, func, y}

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_issuer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] f,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (f)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = (a == b) ? WIDTH'(1) : WIDTH'(0);
      4'd3: r = (a < b)  ? WIDTH'(1) : WIDTH'(0);
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic exp_illegal(input logic [3:0] f);
`ifdef ALU_CMD_ISSUER_ILLEGAL_CHK_EN
    return (f == 4'd4) || (f >= 4'd8);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [EW-1:0] expect_rsp(input logic [3:0] f,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {exp_illegal(f), f, ref_alu(f, a, b)};
  endfunction

  // External combinational ALU
  assign bus.alu_y = ref_alu(bus.alu_func, bus.alu_a, bus.alu_b);

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard monitor (samples on the falling edge)
  // ---------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int            rsp_cnt   = 0;
  logic          hold_prev = 1'b0;
  logic [EW-1:0] held;
  logic [EW-1:0] act;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        act = {bus.rsp_illegal, bus.rsp_func, bus.rsp_y};
        if (hold_prev) begin
          check("rsp_hold_valid", bus.rsp_valid, 1);
          check("rsp_hold_data", act, held);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          rsp_cnt++;
          if (exp_q.size() == 0) check("rsp_unexpected", bus.rsp_valid, 0);
          else                   check("rsp_data", act, exp_q.pop_front());
        end
        if (bus.cmd_valid && bus.cmd_ready)
          exp_q.push_back(expect_rsp(bus.cmd_func, bus.cmd_a, bus.cmd_b));
        hold_prev = bus.rsp_valid && !bus.rsp_ready;
        held      = act;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver: offers one command, returns #1 after the accepting edge
  // ---------------------------------------------------------------------
  task automatic send(input logic [3:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic rdy;
    int   n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_func  = f;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    forever begin
      @(negedge clk);
      rdy = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        check("send_timeout", rdy, 1);
        break;
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  function automatic logic [3:0] rand_func();
    logic [3:0] legal [7];
    legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return legal[$urandom_range(0, 6)];
  endfunction

  function automatic logic [WIDTH-1:0] rand_opnd();
    if ($urandom_range(0, 3) == 0) return WIDTH'($urandom_range(0, 3));
    return $urandom;
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  int   acc;
  int   r0;
  logic rdy_s;
  logic fire;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_func  = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_cmd_ready",   bus.cmd_ready, 1);
    check("rst_rsp_valid",   bus.rsp_valid, 0);
    check("rst_rsp_y",       bus.rsp_y, 0);
    check("rst_rsp_func",    bus.rsp_func, 0);
    check("rst_rsp_illegal", bus.rsp_illegal, 0);
    check("rst_alu_a",       bus.alu_a, 0);
    check("rst_alu_b",       bus.alu_b, 0);
    check("rst_alu_func",    bus.alu_func, 0);

    // latency: add 5+7
    bus.rsp_ready = 1'b1;
    send(4'd0, 32'd5, 32'd7);
    check("lat_valid_at_e", bus.rsp_valid, 0);
    check("lat_head_a",     bus.alu_a, 5);
    check("lat_head_b",     bus.alu_b, 7);
    @(posedge clk); #1;
    check("lat_valid_e1",   bus.rsp_valid, 1);
    check("lat_y",          bus.rsp_y, 12);
    check("lat_func",       bus.rsp_func, 0);
    @(posedge clk); #1;
    check("drain_valid",    bus.rsp_valid, 0);
    check("drain_y_hold",   bus.rsp_y, 12);

    // back-to-back sub, eq, ltu
    send(4'd1, 32'd3, 32'd5);
    send(4'd2, 32'd9, 32'd9);
    send(4'd3, 32'hFFFF_FFFF, 32'd1);
    check("b2b_eq_valid", bus.rsp_valid, 1);
    check("b2b_eq_y",     bus.rsp_y, 1);
    @(posedge clk); #1;
    check("b2b_ltu_valid", bus.rsp_valid, 1);
    check("b2b_ltu_y",     bus.rsp_y, 0);
    check("b2b_ltu_func",  bus.rsp_func, 3);
    @(posedge clk); #1;
    check("b2b_idle", bus.rsp_valid, 0);

    // capacity with the consumer stalled
    bus.rsp_ready = 1'b0;
    acc           = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_func  = rand_func();
    bus.cmd_a     = rand_opnd();
    bus.cmd_b     = rand_opnd();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rdy_s = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy_s) begin
        acc++;
        bus.cmd_func = rand_func();
        bus.cmd_a    = rand_opnd();
        bus.cmd_b    = rand_opnd();
      end
    end
    bus.cmd_valid = 1'b0;
    check("cap_accepted", acc, DEPTH + 1);
    check("cap_ready_low", bus.cmd_ready, 0);
    r0 = rsp_cnt;
    bus.rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("cap_drained",    rsp_cnt - r0, DEPTH + 1);
    check("cap_ready_high", bus.cmd_ready, 1);
    check("cap_queue_empty", exp_q.size(), 0);

    // undefined func codes
    send(4'd4, $urandom, $urandom);
    @(posedge clk); #1;
    check("ill_0100_flag", bus.rsp_illegal, exp_illegal(4'd4));
    check("ill_0100_y",    bus.rsp_y, 0);
    send(4'd15, $urandom, $urandom);
    @(posedge clk); #1;
    check("ill_1111_flag", bus.rsp_illegal, exp_illegal(4'd15));
    check("ill_1111_y",    bus.rsp_y, 0);
    send(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF);
    @(posedge clk); #1;
    check("legal_and_flag", bus.rsp_illegal, 0);
    check("legal_and_y",    bus.rsp_y, 32'h00F0_1234);

    // mid-cycle reset with a pending result and three queued commands
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_func(), rand_opnd(), rand_opnd());
    check("rstm_pre_valid", bus.rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rstm_valid",    bus.rsp_valid, 0);
    check("rstm_y",        bus.rsp_y, 0);
    check("rstm_alu_a",    bus.alu_a, 0);
    check("rstm_alu_b",    bus.alu_b, 0);
    check("rstm_alu_func", bus.alu_func, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    check("rstm_ready_after", bus.cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rstm_no_stale",   bus.rsp_valid, 0);
    check("rstm_alu_idle",   bus.alu_func, 0);

    // randomized traffic
    acc = 0;
    r0  = rsp_cnt;
    for (int i = 0; i < 150; i++) begin
      if (!bus.cmd_valid) begin
        bus.cmd_valid = ($urandom_range(0, 99) < 60);
        bus.cmd_func  = rand_func();
        bus.cmd_a     = rand_opnd();
        bus.cmd_b     = rand_opnd();
      end
      bus.rsp_ready = ($urandom_range(0, 99) < 55);
      @(negedge clk);
      fire = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (fire) begin
        acc++;
        bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("rnd_drain_empty", exp_q.size(), 0);
    check("rnd_count",       rsp_cnt - r0, acc);
    check("rnd_idle_ready",  bus.cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU operand interface (a, b, func in; y out).
- Buffers ALU commands from a valid/ready producer (sequencer, switch/serial loader) in a small FIFO.
- Drives one command per cycle onto an external combinational ALU and registers each result.
- Returns results in order on a valid/ready response port, so the producer never depends on combinational ALU timing.

Parameters:
- WIDTH, 32, operand/result width; must match the attached ALU.
- DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command (= !full)
- cmd_func  in  4  ALU function code
- cmd_a  in  WIDTH  operand a
- cmd_b  in  WIDTH  operand b
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_func  out  4  to ALU func
- alu_y  in  WIDTH  from ALU y (combinational in alu_a/alu_b/alu_func)
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer takes result
- rsp_y  out  WIDTH  registered result
- rsp_func  out  4  func code that produced rsp_y
- rsp_illegal  out  1  func code was not a defined ALU operation

Behaviour:
- Func encoding (fixed):
  - 0000 add, 0001 sub, 0010 eq (1/0), 0011 unsigned less-than (1/0)
  - 0101 and, 0110 or, 0111 xor
  - all other codes: ALU returns 0
- Reset (async, any cycle): FIFO pointers and count cleared; rsp_valid=0, rsp_y=0, rsp_func=0, rsp_illegal=0; cmd_ready=1 once rst deasserts. In-flight commands and a held result are discarded.
- Push: cmd_valid && cmd_ready at a rising edge writes {func, a, b} at the write pointer.
- Full: cmd_ready is low when full, even if a pop occurs in the same cycle. No bypass.
- Pointers: log2(DEPTH)+1 bits; the MSB distinguishes full from empty. Wrap-around is natural.
- Issue: issue = !empty && (!rsp_valid || rsp_ready).
  - While !empty, alu_a/alu_b/alu_func drive the FIFO head.
  - While empty, they drive all zeros, i.e. an add of 0+0.
- Capture: on an issue edge, rsp_y <= alu_y, rsp_func <= head func, rsp_valid <= 1, and the head is popped.
- Drain: rsp_ready && rsp_valid with no issue clears rsp_valid; rsp_y holds its value.
- Latency: command accepted at edge E → rsp_valid high after edge E+1, provided the response register is free. Throughput is 1 result/cycle while rsp_ready=1.
- Capacity: with rsp_ready held low, DEPTH+1 commands are absorbed (DEPTH in the FIFO, 1 in the response register). cmd_ready then stays low.
- Simultaneous push and pop, not full: both occur, count unchanged.
- Push into an empty FIFO: the entry becomes visible at the head in the next cycle (no same-cycle issue).
- Ordering: results are returned strictly in command order.
- Response stability: while rsp_valid && !rsp_ready, rsp_y, rsp_func and rsp_illegal hold stable.

Optional Feature:
- Macro: ALU_CMD_ISSUER_ILLEGAL_CHK_EN
- Defined: rsp_illegal is registered with the result and is 1 when the func code is 0100 or 1xxx. The code is still forwarded to the ALU and rsp_y carries the ALU's 0.
- Undefined: rsp_illegal is tied to 0 and no decode logic is built.

Decomposition:
- Package alu_pkg:
  - func code localparams (ALU_ADD, ALU_SUB, ALU_EQ, ALU_LTU, ALU_AND, ALU_OR, ALU_XOR)
  - ALU_FUNC_W=4
  - function is_legal_func
- One sub-module is natural: cmd_fifo, a parameterised synchronous FIFO (WIDTH*2+4 data, DEPTH) with full/empty flags and async active-high reset.
- Issue/response logic stays in the top module.

Test Plan:
- Push {0000, 5, 7}, rsp_ready=1 → rsp_valid after edge E+1; rsp_y=12, rsp_func=0000.
- Back-to-back sub 3−5, eq 9==9, ltu 0xFFFFFFFF<1 → in order: 0xFFFFFFFE, 1, 0; one result per cycle.
- DEPTH=4, rsp_ready=0, cmd_valid held → exactly 5 accepted, then cmd_ready=0. Raise rsp_ready → 5 results in order, then cmd_ready=1.
- Push func 0100 and 1111 with macro defined → rsp_y=0, rsp_illegal=1. Without the macro → rsp_illegal=0.
- Fill 3 entries with a result pending, then pulse rst mid-cycle → rsp_valid=0 immediately, FIFO empty, alu_* outputs=0, no stale result after release.
- Alternate push/pop with rsp_ready toggling for 100 random cycles → pointers wrap correctly; scoreboard matches a reference ALU model.
